// File: rtl/processador_pkg.sv
// Shared definitions for the uniciclo processor: opcodes, instruction field
// positions and the fetch-stage state encoding.
package processador_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_J    = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 13;
  localparam int RS_MSB   = 12;
  localparam int RS_LSB   = 10;
  localparam int RT_MSB   = 9;
  localparam int RT_LSB   = 7;
  localparam int RD_MSB   = 6;
  localparam int RD_LSB   = 4;
  localparam int IMM_MSB  = 6;
  localparam int IMM_LSB  = 0;
  localparam int HALT_BIT = 0;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } estado_t;

endpackage

// File: rtl/memoria_instrucoes.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module memoria_instrucoes #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clock,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: program counter, loadable instruction memory,
// LOAD/RUN/HALTED control and a saturating retired-instruction counter.
module busca_instrucao
  import processador_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               jump,
  input  logic               beq,
  input  logic               halt,
  input  logic               zero,
  output logic [INSTR_W-1:0] instrucao,
  output logic [2:0]         OPcode,
  output logic               bit_menos_sig,
  output logic [ADDR_W-1:0]  pc,
  output logic               executando,
  output logic               parado,
  output logic [15:0]        contador_instrucoes
);

  estado_t           estado;
  logic [ADDR_W-1:0] pc_next;
  logic              mem_we;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // imm7 sign-extended to the PC width; the offset then wraps with the PC.
  function automatic logic [ADDR_W-1:0] sext_imm(input logic [6:0] imm);
    return {{(ADDR_W-7){imm[6]}}, imm};
  endfunction

  // Reset also blocks the write so a reset edge never corrupts the program.
  assign mem_we = prog_we && (estado == ST_LOAD) && !reset;

  memoria_instrucoes #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (instrucao)
  );

  assign OPcode        = instrucao[OP_MSB:OP_LSB];
  assign bit_menos_sig = instrucao[HALT_BIT];
  assign executando    = (estado == ST_RUN);
  assign parado        = (estado == ST_HALTED);

  always_comb begin
    pc_next = pc + ADDR_W'(1);
    if (jump)
      pc_next = instrucao[ADDR_W-1:0];
    else if (beq && zero)
      pc_next = pc + ADDR_W'(1) + sext_imm(instrucao[IMM_MSB:IMM_LSB]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado              <= ST_LOAD;
      pc                  <= '0;
      contador_instrucoes <= '0;
    end else begin
      case (estado)
        ST_LOAD: begin
          if (start) estado <= ST_RUN;
        end
        ST_RUN: begin
          contador_instrucoes <= sat_inc(contador_instrucoes);
          if (halt) estado <= ST_HALTED;
          else      pc     <= pc_next;
        end
        ST_HALTED: ;
        default: estado <= ST_LOAD;
      endcase
    end
  end

endmodule
